// File: rtl/rv_dmem_ctrl.sv
// Data-memory access controller: runs one req/gnt/rvalid bus transaction per MEM-stage access,
// stalls the pipeline while it is outstanding and aborts with err_o after TIMEOUT cycles.
module rv_dmem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] addr_map_i,
    input  logic [7:0]  wr_strobe_i,
    input  logic [63:0] wr_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [63:0] rd_data_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [7:0]  dmem_strb_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [63:0] dmem_rdata_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StReq  = 3'd1;
    localparam logic [2:0] StWait = 3'd2;
    localparam logic [2:0] StDone = 3'd3;
    localparam logic [2:0] StErr  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [63:0]     addr_q, addr_d;
    logic [7:0]      strb_q, strb_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [63:0]     rd_data_q, rd_data_d;

    // Only the byte offset of addr_i matters; the word address comes from the mapper.
    logic unused_addr;
    assign unused_addr = ^addr_i[63:3];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        case (state_q)
            StIdle: begin
                if (lsu_req_i) begin
                    we_d    = lsu_we_i;
                    addr_d  = addr_map_i;
                    strb_d  = wr_strobe_i;
                    wdata_d = wr_data_i << {addr_i[2:0], 3'b000};
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_gnt_i) begin
                    state_d = StWait;
                end else if (cnt_q >= CntLast) begin
                    rd_data_d = '0;
                    state_d   = StErr;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // A late grant leaves the count past CntLast; the first WAIT cycle is then the last.
                if (dmem_rvalid_i) begin
                    if (!we_q) begin
                        rd_data_d = dmem_rdata_i;
                    end
                    state_d = StDone;
                end else if (cnt_q >= CntLast) begin
                    rd_data_d = '0;
                    state_d   = StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign stall_o      = ((state_q == StIdle) && lsu_req_i) || (state_q == StReq) ||
                          (state_q == StWait);
    assign done_o       = (state_q == StDone);
    assign err_o        = (state_q == StErr);
    assign rd_data_o    = rd_data_q;
    assign dmem_req_o   = (state_q == StReq);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_strb_o  = strb_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Directed bench for rv_dmem_ctrl with TIMEOUT=4: load, store alignment, delayed grant,
// timeout abort, early rvalid and reset during WAIT.
module tb_rv_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req, lsu_we;
    logic [63:0] addr, addr_map, wr_data;
    logic [7:0]  wr_strobe;
    logic        stall, done, err;
    logic [63:0] rd_data;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_strb;
    logic        dmem_gnt, dmem_rvalid;
    logic [63:0] dmem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .lsu_req_i    (lsu_req),
        .lsu_we_i     (lsu_we),
        .addr_i       (addr),
        .addr_map_i   (addr_map),
        .wr_strobe_i  (wr_strobe),
        .wr_data_i    (wr_data),
        .stall_o      (stall),
        .done_o       (done),
        .err_o        (err),
        .rd_data_o    (rd_data),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_strb_o  (dmem_strb),
        .dmem_wdata_o (dmem_wdata),
        .dmem_gnt_i   (dmem_gnt),
        .dmem_rvalid_i(dmem_rvalid),
        .dmem_rdata_i (dmem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge, inputs settle 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic start(input logic we, input logic [63:0] a, input logic [63:0] amap,
                         input logic [7:0] strb, input logic [63:0] wd);
        lsu_req   = 1'b1;
        lsu_we    = we;
        addr      = a;
        addr_map  = amap;
        wr_strobe = strb;
        wr_data   = wd;
    endtask

    initial begin
        rst = 1'b1; lsu_req = 1'b0; lsu_we = 1'b0; addr = '0; addr_map = '0;
        wr_strobe = '0; wr_data = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        settle();
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rd_data, 0);
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_strb", dmem_strb, 0);
        check("rst_wdata", dmem_wdata, 0);

        // Zero-wait load: accept N, req N+1, rvalid N+2, done N+3.
        start(1'b0, 64'h1000, 64'h1000, 8'hFF, 64'h0);
        settle();
        check("ld_stall_n", stall, 1);
        tick();
        check("ld_req_n1", dmem_req, 1);
        check("ld_addr_n1", dmem_addr, 64'h1000);
        check("ld_stall_n1", stall, 1);
        dmem_gnt = 1'b1;
        tick();
        check("ld_req_n2", dmem_req, 0);
        check("ld_stall_n2", stall, 1);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_0123_4567;
        tick();
        dmem_rvalid = 1'b0;
        settle();
        check("ld_done_n3", done, 1);
        check("ld_stall_n3", stall, 0);
        check("ld_rdata", rd_data, 64'hDEAD_BEEF_0123_4567);
        lsu_req = 1'b0;
        tick();
        check("ld_done_clr", done, 0);
        check("ld_stall_idle", stall, 0);

        // Store with byte offset 4: data lands in the upper word half.
        start(1'b1, 64'h0000_0000_0000_1004, 64'h1000, 8'hF0, 64'h1122_3344);
        tick();
        check("st_we", dmem_we, 1);
        check("st_wdata", dmem_wdata, 64'h1122_3344_0000_0000);
        check("st_strb", dmem_strb, 8'hF0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        dmem_rvalid = 1'b0;
        check("st_done", done, 1);
        check("st_rdata_kept", rd_data, 64'hDEAD_BEEF_0123_4567);
        lsu_req = 1'b0;
        tick();

        // Grant on the 4th REQ cycle (the timeout cycle) wins; bus signals held stable.
        start(1'b0, 64'h2000, 64'h2000, 8'h0F, 64'hAB);
        tick();
        addr_map = 64'hFFFF; wr_strobe = 8'h55; wr_data = 64'h77; addr = 64'h7;
        for (int i = 0; i < 4; i++) begin
            check("dl_req", dmem_req, 1);
            check("dl_addr", dmem_addr, 64'h2000);
            check("dl_strb", dmem_strb, 8'h0F);
            check("dl_wdata", dmem_wdata, 64'hAB);
            if (i == 3) dmem_gnt = 1'b1;
            tick();
        end
        dmem_gnt = 1'b0;
        check("dl_wait_noerr", err, 0);
        check("dl_wait_req", dmem_req, 0);
        dmem_rvalid = 1'b1; dmem_rdata = 64'h0A0B_0C0D_0E0F_1011;
        tick();
        dmem_rvalid = 1'b0;
        check("dl_done", done, 1);
        check("dl_rdata", rd_data, 64'h0A0B_0C0D_0E0F_1011);
        lsu_req = 1'b0;
        tick();
        check("dl_done_once", done, 0);

        // Timeout: no grant for 4 REQ cycles.
        start(1'b0, 64'h3000, 64'h3000, 8'hFF, 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_req", dmem_req, 1);
            check("to_noerr", err, 0);
        end
        tick();
        check("to_err", err, 1);
        check("to_stall", stall, 0);
        check("to_rdata", rd_data, 0);
        lsu_req = 1'b0;
        tick();
        check("to_err_clr", err, 0);
        check("to_idle_req", dmem_req, 0);

        // rvalid together with gnt is ignored; only the WAIT-cycle response counts.
        start(1'b0, 64'h4000, 64'h4000, 8'hFF, 64'h0);
        tick();
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'h1111;
        tick();
        check("ev_no_done", done, 0);
        check("ev_rdata_old", rd_data, 0);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 64'h2222;
        tick();
        dmem_rvalid = 1'b0;
        check("ev_done", done, 1);
        check("ev_rdata", rd_data, 64'h2222);
        lsu_req = 1'b0;
        tick();
        check("ev_done_once", done, 0);

        // Reset while in WAIT; later rvalid must not complete anything.
        start(1'b0, 64'h5000, 64'h5000, 8'hFF, 64'h0);
        tick();
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        rst = 1'b1; lsu_req = 1'b0;
        tick();
        rst = 1'b0;
        check("rw_req", dmem_req, 0);
        check("rw_rdata", rd_data, 0);
        check("rw_addr", dmem_addr, 0);
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 64'h3333;
        tick();
        dmem_rvalid = 1'b0;
        check("rw_no_done", done, 0);
        check("rw_stall", stall, 0);
        check("rw_rdata2", rd_data, 0);
        check("rw_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
